hazard_stall_ctrl: RTL

Hazard/stall controller for the 5-stage MIPS pipeline. It produces the `stall_id_ex` bubble request consumed by the ID/EX pipeline register, plus the PC and IF/ID hold signals. It detects load-use and ID-resolved branch operand hazards from ID/EX/MEM register fields, then sequences one or two bubble cycles. A small FSM commits the bubble count at detection time, independent of later inputs.

---
 rtl/hazard_stall_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / ID-branch hazard detection and bubble
// sequencing for the 5-stage MIPS pipeline. Detection is combinational; a
// small RUN/HOLD FSM carries the second bubble of a branch-on-EX-load hazard
// so the bubble count is fixed at detection time.
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating stall-cycle
// counters split by cause (load-use vs branch); without it both perf ports
// read zero.
module hazard_stall_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_Rs,
    input  logic [4:0]  id_Rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_is_branch,
    input  logic [4:0]  ex_wreg,
    input  logic        ex_RegWrite,
    input  logic        ex_MemRead,
    input  logic [4:0]  mem_wreg,
    input  logic        mem_MemRead,
    input  logic        flush,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        stall_id_ex,
    output logic        hazard_busy,
    output logic [31:0] perf_lu_cnt,
    output logic [31:0] perf_br_cnt
);

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HOLD = 2'b01
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  left_q, left_d;
    logic        ex_hit, mem_hit;
    logic [1:0]  demand;
    logic        stall_all;
    logic        busy;

    // Register-match terms; $zero never produces a hit.
    always_comb begin
        ex_hit  = (ex_wreg != 5'd0) &&
                  ((id_use_rs && (ex_wreg == id_Rs)) ||
                   (id_use_rt && (ex_wreg == id_Rt)));
        mem_hit = (mem_wreg != 5'd0) &&
                  ((id_use_rs && (mem_wreg == id_Rs)) ||
                   (id_use_rt && (mem_wreg == id_Rt)));
    end

    // Bubble demand: maximum of all applicable hazard terms.
    always_comb begin
        demand = 2'd0;
        if ((ex_MemRead && ex_hit) ||
            (id_is_branch && ex_RegWrite && !ex_MemRead && ex_hit) ||
            (id_is_branch && mem_MemRead && mem_hit)) begin
            demand = 2'd1;
        end
        if (id_is_branch && ex_MemRead && ex_hit) begin
            demand = 2'd2;
        end
    end

    // FSM next state and stall outputs; reset, then flush, take priority.
    always_comb begin
        state_d   = state_q;
        left_d    = left_q;
        stall_all = 1'b0;
        busy      = 1'b0;
        if (!rst) begin
            state_d = RUN;
            left_d  = 2'd0;
        end else if (flush) begin
            state_d = RUN;
            left_d  = 2'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (demand != 2'd0) begin
                        stall_all = 1'b1;
                    end
                    if (demand == 2'd2) begin
                        state_d = HOLD;
                        left_d  = 2'd1;
                    end
                end
                HOLD: begin
                    stall_all = 1'b1;
                    busy      = 1'b1;
                    left_d    = left_q - 2'd1;
                    if (left_q == 2'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    left_d  = 2'd0;
                end
            endcase
        end
    end

    // FSM state register (synchronous active-low reset).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            left_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
        end
    end

    assign pc_stall    = stall_all;
    assign if_id_stall = stall_all;
    assign stall_id_ex = stall_all;
    assign hazard_busy = busy;

`ifdef HAZARD_PERF_CNT_EN
    logic        cause_br_q, cause_br_d;
    logic        cur_br;
    logic [31:0] lu_cnt_q, lu_cnt_d;
    logic [31:0] br_cnt_q, br_cnt_d;

    // Cause tracking: latched while in RUN, held across HOLD; saturating counts.
    always_comb begin
        cause_br_d = (state_q == RUN) ? id_is_branch : cause_br_q;
        cur_br     = (state_q == HOLD) ? cause_br_q : id_is_branch;
        lu_cnt_d   = lu_cnt_q;
        br_cnt_d   = br_cnt_q;
        if (stall_all && !cur_br && (lu_cnt_q != 32'hFFFF_FFFF)) begin
            lu_cnt_d = lu_cnt_q + 32'd1;
        end
        if (stall_all && cur_br && (br_cnt_q != 32'hFFFF_FFFF)) begin
            br_cnt_d = br_cnt_q + 32'd1;
        end
    end

    // Counter and cause registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cause_br_q <= 1'b0;
            lu_cnt_q   <= 32'd0;
            br_cnt_q   <= 32'd0;
        end else begin
            cause_br_q <= cause_br_d;
            lu_cnt_q   <= lu_cnt_d;
            br_cnt_q   <= br_cnt_d;
        end
    end

    assign perf_lu_cnt = lu_cnt_q;
    assign perf_br_cnt = br_cnt_q;
`else
    assign perf_lu_cnt = 32'h0;
    assign perf_br_cnt = 32'h0;
`endif

endmodule
